// File: rtl/scan_mux.sv
// scan_mux: time-multiplexed digit selector with auto scan or manual select.
// Define SCAN_MUX_BLANK_EN to insert BLANK dead cycles between channels.
module scan_mux #(
  parameter int CH    = 4,
  parameter int W     = 9,
  parameter int DIV   = 1000,
  parameter int BLANK = 2,
  parameter int IDXW  = $clog2(CH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [CH*W-1:0] i_data,
  input  logic [CH-1:0]   i_en,
  input  logic            i_auto,
  input  logic [IDXW-1:0] i_ctrl,
  output logic [W-1:0]    o_data,
  output logic [CH-1:0]   o_dig,
  output logic [IDXW-1:0] o_idx,
  output logic            o_tick
);

`ifdef SCAN_MUX_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  typedef enum logic {S_SHOW, S_BLANK} state_t;

  state_t          r_state, w_state_nx;
  logic [IDXW-1:0] r_idx, w_idx_nx, w_nxt_en, w_cur;
  logic [DW-1:0]   r_dcnt, w_dcnt_nx;
  logic [BW-1:0]   r_bcnt, w_bcnt_nx;
  logic            r_adv, w_adv, w_show, w_wrap, w_any;
  logic [W-1:0]    r_data, w_data;
  logic [CH-1:0]   r_dig, w_dig;
  logic [IDXW-1:0] r_oidx;
  logic            r_tick;

  assign w_any  = |i_en;
  assign w_wrap = (r_dcnt == DW'(DIV - 1));
  assign w_cur  = i_auto ? r_idx : i_ctrl;
  assign w_show = !i_auto || (r_state == S_SHOW);

  // nearest enabled channel above r_idx, wrapping; r_idx itself ranks last
  always_comb begin
    int d;
    int best;
    best     = CH + 1;
    w_nxt_en = r_idx;
    for (int j = 0; j < CH; j++) begin
      d = (j - int'(r_idx) + 2 * CH) % CH;
      if (d == 0) d = CH;
      if (i_en[j] && d < best) begin
        best     = d;
        w_nxt_en = IDXW'(j);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_dcnt_nx  = r_dcnt;
    w_bcnt_nx  = r_bcnt;
    w_adv      = 1'b0;
    if (!i_auto) begin
      w_state_nx = S_SHOW;
      w_idx_nx   = i_ctrl;
      w_dcnt_nx  = '0;
      w_bcnt_nx  = '0;
    end else if (r_state == S_BLANK) begin
      if (r_bcnt == BW'(BLANK - 1)) begin
        w_state_nx = S_SHOW;
        w_bcnt_nx  = '0;
      end else begin
        w_bcnt_nx = r_bcnt + BW'(1);
      end
    end else if (w_wrap) begin
      w_dcnt_nx = '0;
      if (w_any) begin
        w_adv    = 1'b1;
        w_idx_nx = w_nxt_en;
        if (BLANK_ON) w_state_nx = S_BLANK;
      end
    end else begin
      w_dcnt_nx = r_dcnt + DW'(1);
    end
  end

  always_comb begin
    w_dig  = '0;
    w_data = '0;
    for (int j = 0; j < CH; j++) begin
      if (w_show && i_en[j] && w_cur == IDXW'(j)) begin
        w_dig[j] = 1'b1;
        w_data   = i_data[j*W +: W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_SHOW;
      r_idx   <= '0;
      r_dcnt  <= '0;
      r_bcnt  <= '0;
      r_adv   <= 1'b0;
      r_data  <= '0;
      r_dig   <= '0;
      r_oidx  <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_dcnt  <= w_dcnt_nx;
      r_bcnt  <= w_bcnt_nx;
      r_adv   <= w_adv;
      r_data  <= w_data;
      r_dig   <= w_dig;
      r_oidx  <= w_cur;
      r_tick  <= i_auto & r_adv;
    end
  end

  assign o_data = r_data;
  assign o_dig  = r_dig;
  assign o_idx  = r_oidx;
  assign o_tick = r_tick;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: directed phases plus random stimulus vs a cycle model.
// Build with SCAN_MUX_BLANK_EN defined for both files or for neither.
module tb_scan_mux;
  localparam int CH = 4;
  localparam int W = 9;
  localparam int DIV = 4;
  localparam int BLANK = 2;
  localparam int IDXW = 2;
`ifdef SCAN_MUX_BLANK_EN
  localparam int NB = BLANK;
`else
  localparam int NB = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH*W-1:0] data;
  logic [CH-1:0] en;
  logic aut;
  logic [IDXW-1:0] ctrl;
  logic [W-1:0] o_data;
  logic [CH-1:0] o_dig;
  logic [IDXW-1:0] o_idx;
  logic o_tick;

  int n_vec = 0;
  int n_err = 0;
  int n_tick = 0;

  int m_idx, m_left, m_dead;
  bit m_tp;
  logic [W-1:0] e_data;
  logic [CH-1:0] e_dig;
  logic [IDXW-1:0] e_idx;
  logic e_tick;

  always #5 clk = ~clk;

  scan_mux #(
    .CH(CH), .W(W), .DIV(DIV), .BLANK(BLANK), .IDXW(IDXW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_en(en),
    .i_auto(aut), .i_ctrl(ctrl), .o_data(o_data), .o_dig(o_dig),
    .o_idx(o_idx), .o_tick(o_tick)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(int k, int v);
    data[k*W +: W] = W'(v);
  endtask

  function automatic bit en_bit(int k);
    return ((en >> k) & CH'(1)) != '0;
  endfunction

  task automatic model_reset();
    m_idx = 0;
    m_left = DIV;
    m_dead = 0;
    m_tp = 1'b0;
  endtask

  // expected outputs after the coming edge, from model state + live inputs
  task automatic model_eval();
    int cur;
    bit show;
    if (!aut) begin
      cur = int'(ctrl);
      show = 1'b1;
      e_tick = 1'b0;
    end else begin
      cur = m_idx;
      show = (m_dead == 0);
      e_tick = m_tp;
    end
    e_idx = IDXW'(cur);
    e_dig = '0;
    e_data = '0;
    if (show && cur < CH && en_bit(cur)) begin
      e_dig = CH'(1) << cur;
      e_data = data[cur*W +: W];
    end
  endtask

  task automatic model_update();
    int nxt;
    bit found;
    if (!aut) begin
      m_idx = int'(ctrl);
      m_left = DIV;
      m_dead = 0;
      m_tp = 1'b0;
    end else if (m_dead > 0) begin
      m_dead--;
      m_tp = 1'b0;
    end else begin
      m_tp = 1'b0;
      m_left--;
      if (m_left == 0) begin
        m_left = DIV;
        if (en != '0) begin
          nxt = m_idx;
          found = 1'b0;
          for (int k = 1; k <= CH; k++) begin
            if (!found && en_bit((m_idx + k) % CH)) begin
              nxt = (m_idx + k) % CH;
              found = 1'b1;
            end
          end
          m_idx = nxt;
          m_tp = 1'b1;
          m_dead = NB;
        end
      end
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    chk("data", 32'(o_data), 32'(e_data));
    chk("dig", 32'(o_dig), 32'(e_dig));
    chk("idx", 32'(o_idx), 32'(e_idx));
    chk("tick", 32'(o_tick), 32'(e_tick));
    if (o_tick === 1'b1) n_tick++;
    model_update();
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_data"}, 32'(o_data), 32'd0);
    chk({tag, "_dig"}, 32'(o_dig), 32'd0);
    chk({tag, "_idx"}, 32'(o_idx), 32'd0);
    chk({tag, "_tick"}, 32'(o_tick), 32'd0);
  endtask

  task automatic rand_steps(int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < CH; k++) set_word(k, int'($urandom_range(0, 511)));
      if ($urandom_range(0, 9) == 0) en = CH'($urandom);
      if ($urandom_range(0, 19) == 0) aut = ~aut;
      ctrl = IDXW'($urandom);
      step();
    end
  endtask

  initial begin
    bit hit;
    data = '0;
    for (int k = 0; k < CH; k++) set_word(k, k + 1);
    en = '1;
    aut = 1'b1;
    ctrl = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;

    // first frame, then count ticks over a full second frame
    repeat (CH * (DIV + NB)) step();
    n_tick = 0;
    repeat (CH * (DIV + NB)) step();
    chk("frame_ticks", 32'(n_tick), 32'(CH));

    en = 4'b0101;
    repeat (4 * (DIV + NB)) step();
    en = '0;
    repeat (2) step();
    n_tick = 0;
    repeat (8) step();
    chk("off_ticks", 32'(n_tick), 32'd0);

    en = '1;
    aut = 1'b0;
    ctrl = 2'd2;
    step();
    ctrl = 2'd3;
    step();
    ctrl = 2'd0;
    step();

    aut = 1'b1;
    repeat (2) step();
    set_word(0, 7);
    repeat (3) step();

    rand_steps(300);

    // async reset while blanking (mid-dwell when blanking is absent)
    aut = 1'b1;
    en = '1;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      hit = (NB > 0) ? (m_dead > 0) : (m_left > 1 && m_left < DIV);
    end
    chk("rst_window_reached", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (2 * (DIV + NB) + 2) step();

    rand_steps(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
